// File: rtl/disp_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with anti-ghost blanking, PWM
// brightness, leading-zero blanking and frame-synchronous display updates.
module disp_scan_ctrl #(
  parameter int CLK_FREQ_HZ  = 12000000,
  parameter int FRAME_HZ     = 250,
  parameter int BLANK_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] hex,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic [2:0]  brightness,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [7:0]  sseg,
  output logic        frame_start,
  output logic        busy_pending
);

  localparam int SLOT_CYCLES = CLK_FREQ_HZ / (4 * FRAME_HZ);
  localparam int ON_CYCLES   = SLOT_CYCLES - BLANK_CYCLES;
  localparam int SUB_CYCLES  = (ON_CYCLES > 0) ? ON_CYCLES / 8 : 1;
  localparam int BLK_W       = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int SUB_W       = (SUB_CYCLES > 1) ? $clog2(SUB_CYCLES) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLANK_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(SUB_CYCLES - 1);

  if ((ON_CYCLES <= 0) || ((ON_CYCLES % 8) != 0) || (BLANK_CYCLES < 1)) begin : g_bad_cfg
    $error("disp_scan_ctrl: ON_CYCLES must be a positive multiple of 8");
  end

  typedef enum logic [0:0] {ST_BLANK = 1'b0, ST_ON = 1'b1} state_t;

  state_t           state_r;
  logic [1:0]       digit_r;
  logic [BLK_W-1:0] cnt_r;
  logic [SUB_W-1:0] sub_cnt_r;
  logic [2:0]       phase_r;
  logic [2:0]       bright_r;
  logic [15:0]      stage_hex_r, disp_hex_r;
  logic [3:0]       stage_dp_r, disp_dp_r;
  logic             pending_r;
  logic [3:0]       an_r;
  logic [7:0]       sseg_r;
  logic             frame_start_r;

  logic [3:0] cur_val_s;
  logic       cur_dp_s;
  logic [3:0] lz_s;
  logic       blank_digit_s;
  logic       on_drive_s;
  logic [3:0] an_s;
  logic [7:0] sseg_s;
  logic       frame_s;
  logic       commit_s;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Next-cycle output values derived from the current scan position and committed data.
  always_comb begin
    cur_val_s = 4'h0;
    case (digit_r)
      2'd0:    cur_val_s = disp_hex_r[3:0];
      2'd1:    cur_val_s = disp_hex_r[7:4];
      2'd2:    cur_val_s = disp_hex_r[11:8];
      2'd3:    cur_val_s = disp_hex_r[15:12];
      default: cur_val_s = 4'h0;
    endcase
    cur_dp_s = disp_dp_r[digit_r];
    // A digit is a leading zero only if every more-significant digit is also zero.
    lz_s[3] = lz_blank && (disp_hex_r[15:12] == 4'h0);
    lz_s[2] = lz_s[3] && (disp_hex_r[11:8] == 4'h0);
    lz_s[1] = lz_s[2] && (disp_hex_r[7:4] == 4'h0);
    lz_s[0] = 1'b0;
    blank_digit_s = lz_s[digit_r];
    on_drive_s = (state_r == ST_ON) && (phase_r <= bright_r) && !(blank_digit_s && !cur_dp_s);
    if (on_drive_s) begin
      an_s   = ~(4'b0001 << digit_r);
      sseg_s = {~cur_dp_s, blank_digit_s ? 7'h7F : seg_decode(cur_val_s)};
    end else begin
      an_s   = 4'b1111;
      sseg_s = 8'hFF;
    end
    frame_s  = (state_r == ST_BLANK) && (digit_r == 2'd0) && (cnt_r == {BLK_W{1'b0}});
    commit_s = (state_r == ST_ON) && (digit_r == 2'd3) && (phase_r == 3'd7) && (sub_cnt_r == SUB_LAST);
  end

  // Scan FSM, load/commit bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_BLANK;
      digit_r       <= 2'd0;
      cnt_r         <= {BLK_W{1'b0}};
      sub_cnt_r     <= {SUB_W{1'b0}};
      phase_r       <= 3'd0;
      bright_r      <= 3'd0;
      stage_hex_r   <= 16'h0000;
      stage_dp_r    <= 4'h0;
      disp_hex_r    <= 16'h0000;
      disp_dp_r     <= 4'h0;
      pending_r     <= 1'b0;
      an_r          <= 4'b1111;
      sseg_r        <= 8'hFF;
      frame_start_r <= 1'b0;
    end else begin
      an_r          <= an_s;
      sseg_r        <= sseg_s;
      frame_start_r <= frame_s;

      if (commit_s) begin
        if (load) begin
          disp_hex_r <= hex;
          disp_dp_r  <= dp_in;
        end else if (pending_r) begin
          disp_hex_r <= stage_hex_r;
          disp_dp_r  <= stage_dp_r;
        end else begin
          disp_hex_r <= disp_hex_r;
        end
        pending_r <= 1'b0;
      end else if (load) begin
        stage_hex_r <= hex;
        stage_dp_r  <= dp_in;
        pending_r   <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end

      case (state_r)
        ST_BLANK: begin
          if (cnt_r == BLK_LAST) begin
            cnt_r     <= {BLK_W{1'b0}};
            sub_cnt_r <= {SUB_W{1'b0}};
            phase_r   <= 3'd0;
            bright_r  <= brightness;
            state_r   <= ST_ON;
          end else begin
            cnt_r <= cnt_r + BLK_W'(1);
          end
        end
        ST_ON: begin
          if (sub_cnt_r == SUB_LAST) begin
            sub_cnt_r <= {SUB_W{1'b0}};
            if (phase_r == 3'd7) begin
              state_r <= ST_BLANK;
              digit_r <= digit_r + 2'd1;
            end else begin
              phase_r <= phase_r + 3'd1;
            end
          end else begin
            sub_cnt_r <= sub_cnt_r + SUB_W'(1);
          end
        end
        default: state_r <= ST_BLANK;
      endcase
    end
  end

  assign an           = an_r;
  assign sseg         = sseg_r;
  assign frame_start  = frame_start_r;
  assign busy_pending = pending_r;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl: directed scenarios plus random traffic
// compared cycle by cycle against a frame-level reference model.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] hex = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic [2:0]  brightness = 3'd0;
  logic        lz_blank = 1'b0;
  logic [3:0]  an;
  logic [7:0]  sseg;
  logic        frame_start;
  logic        busy_pending;

  int checks = 0;
  int failures = 0;

  disp_scan_ctrl #(.CLK_FREQ_HZ(6400), .FRAME_HZ(100), .BLANK_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .hex(hex), .dp_in(dp_in), .load(load),
    .brightness(brightness), .lz_blank(lz_blank), .an(an), .sseg(sseg),
    .frame_start(frame_start), .busy_pending(busy_pending)
  );

  always #5 clk = ~clk;

  // Reference model: time is counted in cycles since reset release.
  localparam int SLOT = 16;
  localparam int BLANK = 8;
  localparam int FRAME = 64;
  logic [6:0]  dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          k;
  logic [15:0] m_hex, m_stage_hex;
  logic [3:0]  m_dp, m_stage_dp;
  logic        m_pend;
  logic [2:0]  m_bright;

  task automatic model_reset();
    k = 0; m_hex = 16'h0; m_dp = 4'h0; m_stage_hex = 16'h0; m_stage_dp = 4'h0;
    m_pend = 1'b0; m_bright = 3'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // One clock: inputs are already driven at the negedge; outputs checked at the next negedge.
  task automatic step();
    int pos, dig;
    logic [15:0] upper;
    logic blk, dpv, lit, on;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic e_fs;
    pos   = k % SLOT;
    dig   = (k / SLOT) % 4;
    upper = m_hex >> (4 * dig);
    dpv   = m_dp[dig];
    blk   = lz_blank && (dig != 0) && (upper == 16'h0);
    lit   = !(blk && !dpv);
    on    = (pos >= BLANK) && ((pos - BLANK) <= int'(m_bright));
    if (on && lit) begin
      e_an  = ~(4'b0001 << dig);
      e_seg = {~dpv, blk ? 7'h7F : dec[upper[3:0]]};
    end else begin
      e_an  = 4'b1111;
      e_seg = 8'hFF;
    end
    e_fs = ((k % FRAME) == 0);
    if (pos == BLANK - 1) m_bright = brightness;
    if ((k % FRAME) == FRAME - 1) begin
      if (load) begin
        m_hex = hex; m_dp = dp_in;
      end else if (m_pend) begin
        m_hex = m_stage_hex; m_dp = m_stage_dp;
      end
      m_pend = 1'b0;
    end else if (load) begin
      m_stage_hex = hex; m_stage_dp = dp_in; m_pend = 1'b1;
    end
    k++;
    @(posedge clk);
    @(negedge clk);
    check("an", 32'(an), 32'(e_an));
    check("sseg", 32'(sseg), 32'(e_seg));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("busy_pending", 32'(busy_pending), 32'(m_pend));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] d);
    hex = h; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic run_until(input int phase);
    for (int i = 0; i < FRAME && (k % FRAME) != phase; i++) step();
  endtask

  initial begin
    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'hF);
    check("rst_sseg", 32'(sseg), 32'hFF);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    check("rst_busy", 32'(busy_pending), 32'h0);
    reset = 1'b1;

    // First frame_start right after the first edge, then "1234" at full brightness
    brightness = 3'd7;
    run(5);
    do_load(16'h1234, 4'h0);
    check("busy_after_load", 32'(busy_pending), 32'h1);
    run(2 * FRAME);

    // Minimum duty
    brightness = 3'd0;
    run(FRAME + 8);

    // Leading-zero blanking, then with dp on digit 3
    brightness = 3'd7;
    lz_blank = 1'b1;
    do_load(16'h0050, 4'h0);
    run(2 * FRAME);
    do_load(16'h0050, 4'b1000);
    run(2 * FRAME);
    lz_blank = 1'b0;

    // Last load wins
    run_until(20);
    do_load(16'hAAAA, 4'h0);
    step();
    do_load(16'hBBBB, 4'h0);
    run(2 * FRAME);

    // Load on the commit cycle
    run_until(FRAME - 1);
    do_load(16'hC0DE, 4'b0101);
    check("busy_commit_load", 32'(busy_pending), 32'h0);
    run(FRAME + 3);

    // Random traffic
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(15) == 0) brightness = 3'($urandom_range(7));
      if ($urandom_range(63) == 0) lz_blank = ~lz_blank;
      hex   = ($urandom_range(2) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
      dp_in = 4'($urandom);
      load  = ($urandom_range(11) == 0);
      step();
    end
    load = 1'b0;
    lz_blank = 1'b0;

    // Asynchronous reset in the middle of an ON phase
    brightness = 3'd7;
    do_load(16'h9876, 4'h0);
    run_until(FRAME - 6);
    run(6 + SLOT + 10);
    check("pre_rst_an_active", 32'(an == 4'b1111), 32'h0);
    #2 reset = 1'b0;
    #1;
    check("async_rst_an", 32'(an), 32'hF);
    check("async_rst_sseg", 32'(sseg), 32'hFF);
    check("async_rst_busy", 32'(busy_pending), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    run(FRAME + 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
